// File: rtl/ntt_op_sequencer_if.sv
// Job, source-stream and core-command signals of the NTT op sequencer.
// master = host/DMA/core side, slave = sequencer side.
interface ntt_op_sequencer_if #(
  parameter int DW   = 32,
  parameter int OPW  = 5,
  parameter int LENW = 12
);
  logic            job_valid;
  logic            job_ready;
  logic [OPW-1:0]  job_opcode;
  logic [LENW-1:0] job_len;
  logic            job_src;
  logic [LENW-1:0] job_wait;
  logic            job_wait_done;
  logic            src_valid;
  logic [DW-1:0]   src_data;
  logic            src_ready;
  logic            core_done;
  logic [OPW-1:0]  op_code;
  logic            din_valid;
  logic [DW-1:0]   din0;
  logic            job_done;
  logic            job_err;
  logic            busy;

  modport master (
    output job_valid, job_opcode, job_len, job_src, job_wait, job_wait_done,
    output src_valid, src_data, core_done,
    input  job_ready, src_ready, op_code, din_valid, din0, job_done, job_err, busy
  );

  modport slave (
    input  job_valid, job_opcode, job_len, job_src, job_wait, job_wait_done,
    input  src_valid, src_data, core_done,
    output job_ready, src_ready, op_code, din_valid, din0, job_done, job_err, busy
  );
endinterface

// File: rtl/ntt_op_sequencer.sv
// Expands one job descriptor into the NTT core command protocol:
// opcode pulse, din_valid burst, idle gap, then fixed or done-edge wait.
module ntt_op_sequencer #(
  parameter int DW      = 32,
  parameter int OPW     = 5,
  parameter int LENW    = 12,
  parameter int TIMEOUT = 65535
) (
  input  logic               clk,
  input  logic               reset,
  ntt_op_sequencer_if.slave  bus
);

  localparam int TOW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [TOW-1:0] TO_LAST = TOW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_BEATS,
    S_GAP,
    S_WAIT,
    S_DONE
  } state_t;

  state_t          state_reg, state_next;
  logic [OPW-1:0]  opcode_reg;
  logic [LENW-1:0] len_reg;
  logic [LENW-1:0] wait_reg;
  logic            src_mode_reg;
  logic            wait_done_reg;
  logic [LENW-1:0] beat_cnt_reg, beat_cnt_next;
  logic [LENW-1:0] wait_cnt_reg, wait_cnt_next;
  logic [TOW-1:0]  to_cnt_reg, to_cnt_next;
  logic [DW-1:0]   din0_reg, din0_next;
  logic            done_prev_reg, done_prev_next;
  logic            edge_seen_reg, edge_seen_next;
  logic            err_reg, err_next;
  logic            accept;
  logic            beat;
  logic            done_edge;

  assign accept    = (state_reg == S_IDLE) && bus.job_valid;
  assign beat      = (state_reg == S_BEATS) && (!src_mode_reg || bus.src_valid);
  assign done_edge = bus.core_done && !done_prev_reg;

  // Moore outputs; only din0 passes src_data through during a source beat.
  assign bus.job_ready = (state_reg == S_IDLE);
  assign bus.busy      = (state_reg != S_IDLE);
  assign bus.op_code   = (state_reg == S_ISSUE) ? opcode_reg : '0;
  assign bus.din_valid = beat;
  assign bus.din0      = din0_next;
  assign bus.src_ready = (state_reg == S_BEATS) && src_mode_reg;
  assign bus.job_done  = (state_reg == S_DONE);
  assign bus.job_err   = (state_reg == S_DONE) && err_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= S_IDLE;
      opcode_reg    <= '0;
      len_reg       <= '0;
      wait_reg      <= '0;
      src_mode_reg  <= 1'b0;
      wait_done_reg <= 1'b0;
      beat_cnt_reg  <= '0;
      wait_cnt_reg  <= '0;
      to_cnt_reg    <= '0;
      din0_reg      <= '0;
      done_prev_reg <= 1'b0;
      edge_seen_reg <= 1'b0;
      err_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      beat_cnt_reg  <= beat_cnt_next;
      wait_cnt_reg  <= wait_cnt_next;
      to_cnt_reg    <= to_cnt_next;
      din0_reg      <= din0_next;
      done_prev_reg <= done_prev_next;
      edge_seen_reg <= edge_seen_next;
      err_reg       <= err_next;
      if (accept) begin
        opcode_reg    <= bus.job_opcode;
        len_reg       <= bus.job_len;
        wait_reg      <= bus.job_wait;
        src_mode_reg  <= bus.job_src;
        wait_done_reg <= bus.job_wait_done;
      end
    end
  end

  always_comb begin
    state_next     = state_reg;
    beat_cnt_next  = beat_cnt_reg;
    wait_cnt_next  = wait_cnt_reg;
    to_cnt_next    = to_cnt_reg;
    din0_next      = din0_reg;
    done_prev_next = done_prev_reg;
    edge_seen_next = edge_seen_reg;
    err_next       = err_reg;

    // A rise of core_done any time after ISSUE is remembered until WAIT.
    if (state_reg == S_BEATS || state_reg == S_GAP || state_reg == S_WAIT) begin
      done_prev_next = bus.core_done;
    end
    if ((state_reg == S_BEATS || state_reg == S_GAP) && done_edge) begin
      edge_seen_next = 1'b1;
    end

    case (state_reg)
      S_IDLE: begin
        if (accept) begin
          state_next = S_ISSUE;
        end
      end

      S_ISSUE: begin
        beat_cnt_next  = '0;
        wait_cnt_next  = '0;
        to_cnt_next    = '0;
        edge_seen_next = 1'b0;
        err_next       = 1'b0;
        // A level already high here must not count as the completion edge.
        done_prev_next = bus.core_done;
        state_next     = (len_reg != '0) ? S_BEATS : S_GAP;
      end

      S_BEATS: begin
        if (beat) begin
          din0_next     = src_mode_reg ? bus.src_data : '0;
          beat_cnt_next = beat_cnt_reg + LENW'(1);
          if (beat_cnt_next == len_reg) begin
            state_next = S_GAP;
          end
        end
      end

      S_GAP: begin
        if (wait_done_reg || (wait_reg != '0)) begin
          state_next = S_WAIT;
        end else begin
          state_next = S_DONE;
        end
      end

      S_WAIT: begin
        if (wait_done_reg) begin
          if (edge_seen_reg || done_edge) begin
            state_next = S_DONE;
          end else if (to_cnt_reg == TO_LAST) begin
            err_next   = 1'b1;
            state_next = S_DONE;
          end else begin
            to_cnt_next = to_cnt_reg + TOW'(1);
          end
        end else begin
          wait_cnt_next = wait_cnt_reg + LENW'(1);
          if (wait_cnt_next == wait_reg) begin
            state_next = S_DONE;
          end
        end
      end

      S_DONE: begin
        state_next = S_IDLE;
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_ntt_op_sequencer.sv
// Directed bench for ntt_op_sequencer: cycle-exact job timing, streaming,
// stalls, done-edge/timeout completion, reset abort and back-to-back jobs.
module tb_ntt_op_sequencer;
  localparam int DW      = 32;
  localparam int OPW     = 5;
  localparam int LENW    = 12;
  localparam int TIMEOUT = 100;
  localparam logic [31:0] BASE = 32'hA500_0000;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ntt_op_sequencer_if #(.DW(DW), .OPW(OPW), .LENW(LENW)) bus ();

  ntt_op_sequencer #(.DW(DW), .OPW(OPW), .LENW(LENW), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int pass_cnt = 0;
  int total_cnt = 0;

  // Per-job observations, cycle 0 = cycle job_valid is presented.
  int r_accept, r_pulses, r_issue, r_opval, r_beats, r_first, r_last;
  int r_data_err, r_proto_err, r_words, r_done, r_err, r_ready_after;

  task automatic drive_idle();
    bus.job_valid = 0; bus.job_opcode = '0; bus.job_len = '0; bus.job_src = 0;
    bus.job_wait = '0; bus.job_wait_done = 0; bus.src_valid = 0;
    bus.src_data = '0; bus.core_done = 0;
  endtask

  // stall_mode 0: src always valid; 1: src valid only on odd cycles.
  task automatic run_job(input logic [4:0] opc, input int len, input bit src,
                         input int wt, input bit wd, input int stall_mode,
                         input bit cd_init, input int cd_fall, input int cd_rise,
                         input int bound);
    int widx;
    bit done;
    logic [31:0] exp_d;
    widx = 0; done = 0;
    r_accept = 0; r_pulses = 0; r_issue = -1; r_opval = 0; r_beats = 0;
    r_first = -1; r_last = -1; r_data_err = 0; r_proto_err = 0; r_done = -1; r_err = 0;
    for (int t = 0; t < bound && !done; t++) begin
      @(negedge clk);
      if (t == 0) begin
        bus.job_opcode = opc; bus.job_len = LENW'(len); bus.job_src = src;
        bus.job_wait = LENW'(wt); bus.job_wait_done = wd; bus.job_valid = 1;
      end else begin
        bus.job_valid = 0;
      end
      if (cd_rise >= 0 && t >= cd_rise) bus.core_done = 1;
      else if (cd_fall >= 0 && t >= cd_fall) bus.core_done = 0;
      else bus.core_done = cd_init;
      bus.src_valid = (stall_mode == 0) ? 1'b1 : ((t % 2) == 1);
      bus.src_data = BASE + 32'(widx);
      #1;
      if (t == 0) r_accept = int'(bus.job_ready);
      if (bus.op_code !== '0) begin
        r_pulses++; r_issue = t; r_opval = int'(bus.op_code);
        if (bus.din_valid) r_proto_err++;
      end
      if (bus.din_valid) begin
        r_beats++;
        if (r_first < 0) r_first = t;
        r_last = t;
        exp_d = src ? (BASE + 32'(widx)) : 32'h0;
        if (bus.din0 !== exp_d) r_data_err++;
      end
      if (!src && bus.src_ready) r_proto_err++;
      if (src && (bus.din_valid !== (bus.src_valid && bus.src_ready))) r_proto_err++;
      if (bus.src_valid && bus.src_ready) widx++;
      if (bus.job_done) begin
        done = 1; r_done = t; r_err = int'(bus.job_err);
      end
    end
    r_words = widx;
    @(negedge clk);
    drive_idle();
    #1;
    r_ready_after = int'(bus.job_ready);
    $display("job op=%05b len=%0d src=%0b wait=%0d wd=%0b: issue@%0d beats=%0d words=%0d done@%0d err=%0d",
             opc, len, src, wt, wd, r_issue, r_beats, r_words, r_done, r_err);
  endtask

  task automatic test_reset();
    reset = 1;
    drive_idle();
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 0;
    #1;
    total_cnt++; if (bus.op_code !== '0) $display("FAIL reset_op_code: got %0d expected 0", bus.op_code); else pass_cnt++;
    total_cnt++; if (bus.din_valid !== 1'b0) $display("FAIL reset_din_valid: got %0b expected 0", bus.din_valid); else pass_cnt++;
    total_cnt++; if (bus.din0 !== '0) $display("FAIL reset_din0: got %0h expected 0", bus.din0); else pass_cnt++;
    total_cnt++; if (bus.src_ready !== 1'b0) $display("FAIL reset_src_ready: got %0b expected 0", bus.src_ready); else pass_cnt++;
    total_cnt++; if (bus.job_done !== 1'b0 || bus.job_err !== 1'b0) $display("FAIL reset_done_err: got %0b/%0b expected 0/0", bus.job_done, bus.job_err); else pass_cnt++;
    total_cnt++; if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %0b expected 0", bus.busy); else pass_cnt++;
    total_cnt++; if (bus.job_ready !== 1'b1) $display("FAIL reset_job_ready: got %0b expected 1", bus.job_ready); else pass_cnt++;
    $display("reset: idle outputs checked");
  endtask

  task automatic test_stream_736();
    run_job(5'b00010, 736, 1, 0, 0, 0, 0, -1, -1, 2000);
    total_cnt++; if (r_accept !== 1) $display("FAIL s736_accept: got %0d expected 1", r_accept); else pass_cnt++;
    total_cnt++; if (r_pulses !== 1 || r_issue !== 1) $display("FAIL s736_pulse: got %0d pulses at %0d expected 1 at 1", r_pulses, r_issue); else pass_cnt++;
    total_cnt++; if (r_opval !== 2) $display("FAIL s736_opcode: got %0d expected 2", r_opval); else pass_cnt++;
    total_cnt++; if (r_beats !== 736 || r_first !== 2 || r_last !== 737) $display("FAIL s736_beats: got %0d in %0d..%0d expected 736 in 2..737", r_beats, r_first, r_last); else pass_cnt++;
    total_cnt++; if (r_data_err !== 0 || r_words !== 736) $display("FAIL s736_data: got %0d errors %0d words expected 0 errors 736 words", r_data_err, r_words); else pass_cnt++;
    total_cnt++; if (r_proto_err !== 0) $display("FAIL s736_proto: got %0d expected 0", r_proto_err); else pass_cnt++;
    total_cnt++; if (r_done !== 739 || r_err !== 0) $display("FAIL s736_done: got cycle %0d err %0d expected 739 err 0", r_done, r_err); else pass_cnt++;
    total_cnt++; if (r_ready_after !== 1) $display("FAIL s736_ready_after: got %0d expected 1", r_ready_after); else pass_cnt++;
  endtask

  task automatic test_stall_512();
    run_job(5'b00011, 512, 1, 0, 0, 1, 0, -1, -1, 3000);
    total_cnt++; if (r_beats !== 512 || r_first !== 3 || r_last !== 1025) $display("FAIL s512_beats: got %0d in %0d..%0d expected 512 in 3..1025", r_beats, r_first, r_last); else pass_cnt++;
    total_cnt++; if (r_data_err !== 0 || r_words !== 512) $display("FAIL s512_data: got %0d errors %0d words expected 0 errors 512 words", r_data_err, r_words); else pass_cnt++;
    total_cnt++; if (r_proto_err !== 0) $display("FAIL s512_proto: got %0d expected 0", r_proto_err); else pass_cnt++;
    total_cnt++; if (r_opval !== 3 || r_pulses !== 1) $display("FAIL s512_opcode: got %0d x%0d expected 3 x1", r_opval, r_pulses); else pass_cnt++;
    total_cnt++; if (r_done !== 1027) $display("FAIL s512_done: got %0d expected 1027", r_done); else pass_cnt++;
  endtask

  task automatic test_len0_wait84();
    run_job(5'b00100, 0, 0, 84, 0, 0, 0, -1, -1, 300);
    total_cnt++; if (r_issue !== 1 || r_opval !== 4 || r_pulses !== 1) $display("FAIL l0_issue: got op %0d at %0d x%0d expected 4 at 1 x1", r_opval, r_issue, r_pulses); else pass_cnt++;
    total_cnt++; if (r_beats !== 0) $display("FAIL l0_no_beats: got %0d expected 0", r_beats); else pass_cnt++;
    total_cnt++; if (r_done !== 87 || r_err !== 0) $display("FAIL l0_done: got %0d err %0d expected 87 err 0", r_done, r_err); else pass_cnt++;
  endtask

  task automatic test_wait_done();
    run_job(5'b01000, 17, 0, 0, 1, 0, 1, 5, 55, 400);
    total_cnt++; if (r_beats !== 17 || r_first !== 2 || r_data_err !== 0) $display("FAIL wd_beats: got %0d from %0d errs %0d expected 17 from 2 errs 0", r_beats, r_first, r_data_err); else pass_cnt++;
    total_cnt++; if (r_proto_err !== 0 || r_words !== 0) $display("FAIL wd_src_ready: got %0d/%0d expected 0/0", r_proto_err, r_words); else pass_cnt++;
    total_cnt++; if (r_done !== 56 || r_err !== 0) $display("FAIL wd_done: got %0d err %0d expected 56 err 0", r_done, r_err); else pass_cnt++;
    run_job(5'b01000, 17, 0, 0, 1, 0, 0, -1, -1, 400);
    total_cnt++; if (r_err !== 1) $display("FAIL to_err: got %0d expected 1", r_err); else pass_cnt++;
    total_cnt++; if (r_done < 19 + TIMEOUT || r_done > 22 + TIMEOUT) $display("FAIL to_cycle: got %0d expected %0d..%0d", r_done, 19 + TIMEOUT, 22 + TIMEOUT); else pass_cnt++;
  endtask

  task automatic test_reset_mid_beats();
    int widx, beats, dones;
    widx = 0; beats = 0; dones = 0;
    for (int t = 0; t <= 42; t++) begin
      @(negedge clk);
      if (t == 0) begin
        bus.job_opcode = 5'b00101; bus.job_len = 12'd128; bus.job_src = 1;
        bus.job_wait = '0; bus.job_wait_done = 0; bus.job_valid = 1;
      end else begin
        bus.job_valid = 0;
      end
      bus.src_valid = 1; bus.src_data = BASE + 32'(widx);
      if (t == 42) reset = 1;
      #1;
      if (t <= 41 && bus.din_valid) beats++;
      if (bus.src_valid && bus.src_ready) widx++;
    end
    total_cnt++; if (beats !== 40) $display("FAIL rst_beats_before: got %0d expected 40", beats); else pass_cnt++;
    total_cnt++; if (bus.src_ready !== 1'b1) $display("FAIL rst_src_ready_before: got %0b expected 1", bus.src_ready); else pass_cnt++;
    @(negedge clk);
    #1;
    total_cnt++; if (bus.din_valid !== 1'b0 || bus.src_ready !== 1'b0 || bus.op_code !== '0 || bus.din0 !== '0) $display("FAIL rst_outputs: got dv=%0b sr=%0b op=%0d d=%0h expected all 0", bus.din_valid, bus.src_ready, bus.op_code, bus.din0); else pass_cnt++;
    total_cnt++; if (bus.busy !== 1'b0 || bus.job_ready !== 1'b1) $display("FAIL rst_state: got busy=%0b ready=%0b expected 0/1", bus.busy, bus.job_ready); else pass_cnt++;
    for (int t = 0; t < 12; t++) begin
      @(negedge clk);
      if (t == 0) reset = 0;
      bus.src_valid = 0;
      #1;
      if (bus.job_done || bus.busy) dones++;
    end
    total_cnt++; if (dones !== 0) $display("FAIL rst_no_done: got %0d expected 0", dones); else pass_cnt++;
    drive_idle();
    $display("job op=00101 len=128 aborted by reset after 40 beats");
  endtask

  task automatic test_back_to_back();
    int p0, p1, v0, v1, np, d0, d1, nd;
    p0 = -1; p1 = -1; v0 = 0; v1 = 0; np = 0; d0 = -1; d1 = -1; nd = 0;
    for (int t = 0; t < 16; t++) begin
      @(negedge clk);
      if (t == 0) begin
        bus.job_opcode = 5'b00110; bus.job_len = 12'd2; bus.job_src = 0;
        bus.job_wait = 12'd1; bus.job_wait_done = 0; bus.job_valid = 1;
      end else if (t == 1) begin
        bus.job_opcode = 5'b01001; bus.job_len = 12'd0; bus.job_wait = 12'd0;
      end else if (t == 8) begin
        bus.job_valid = 0;
      end
      #1;
      if (bus.op_code !== '0) begin
        np++;
        if (p0 < 0) begin p0 = t; v0 = int'(bus.op_code); end
        else begin p1 = t; v1 = int'(bus.op_code); end
      end
      if (bus.job_done) begin
        nd++;
        if (d0 < 0) d0 = t; else d1 = t;
      end
    end
    drive_idle();
    total_cnt++; if (np !== 2 || p0 !== 1 || v0 !== 6) $display("FAIL b2b_first_pulse: got %0d pulses, first op %0d at %0d expected 2, op 6 at 1", np, v0, p0); else pass_cnt++;
    total_cnt++; if (p1 !== 8 || v1 !== 9) $display("FAIL b2b_second_pulse: got op %0d at %0d expected op 9 at 8", v1, p1); else pass_cnt++;
    total_cnt++; if (nd !== 2 || d0 !== 6 || d1 !== 10) $display("FAIL b2b_done: got %0d dones at %0d,%0d expected 2 at 6,10", nd, d0, d1); else pass_cnt++;
    $display("back-to-back: jobs issued at %0d and %0d, done at %0d and %0d", p0, p1, d0, d1);
  endtask

  initial begin
    test_reset();
    test_stream_736();
    test_stall_512();
    test_len0_wait84();
    test_wait_done();
    test_reset_mid_beats();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
